player_sprite_ctrl: RTL and testbench
=====================================

# player_sprite_ctrl

Maze player position and sprite-window controller for the VGA path. Holds the player's tile and pixel position, and accepts WASD keycodes. Once per frame it steps the sprite one tile at a time, honouring wall flags from the maze map. Per pixel it generates `DistX`/`DistY`/`sprite_on`, which feed the sprite ROM/palette draw stage directly downstream.

## Interface
- `TILE`, 20: tile edge in pixels; equals sprite width and height.
- `STEP`, 2: pixels moved per frame tick; `TILE % STEP == 0` is required.
- `GRID_W`, 32: tiles per row.
- `GRID_H`, 24: tiles per column.
- `START_X`, 1: reset tile column.
- `START_Y`, 1: reset tile row.

Ports:
- `vga_clk` in 1: pixel clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `vs` in 1: VGA vertical sync, active low.
- `DrawX` in 10: current pixel column.
- `DrawY` in 10: current pixel row.
- `keycode` in 8: USB HID keycode.
- `key_valid` in 1: `keycode` is valid this cycle.
- `blocked` in 4: wall flags for neighbours of (`tile_x`,`tile_y`); bit 0 = up, 1 = right, 2 = down, 3 = left.
- `tile_x` out 5: current tile column.
- `tile_y` out 5: current tile row.
- `DistX` out 20: `DrawX` minus sprite left edge, zero-extended.
- `DistY` out 20: `DrawY` minus sprite top edge, zero-extended.
- `sprite_on` out 1: the pixel lies inside the sprite window.
- `facing` out 2: 0 = up, 1 = right, 2 = down, 3 = left.
- `moving` out 1: the FSM is in MOVE.
- `walk_frame` out 2: animation frame index.

## Operation
- Frame tick: one-cycle pulse, asserted the cycle after a registered falling edge of `vs`. All motion happens only on a tick.
- Key latch:
  - `key_valid` with keycode 0x1A, 0x07, 0x16 or 0x04 (W/D/S/A) stores request dir 0/1/2/3 and sets `req_pending`.
  - Other keycodes are ignored.
  - A later valid key overwrites an earlier one.
- FSM states: IDLE, MOVE.
- IDLE, on a tick with `req_pending`:
  - `facing` ← request and `req_pending` ← 0. This happens even if the move is refused (turn in place).
  - The move is refused if `blocked[dir]` is set, or the target tile is outside 0..`GRID_W`-1 / 0..`GRID_H`-1.
  - If the move is accepted: `remaining` ← `TILE`, go to MOVE.
- MOVE, on each tick:
  - `pix_x`/`pix_y` move `STEP` in direction `facing`, and `remaining` decreases by `STEP`.
  - When `remaining` reaches 0: `tile_x`/`tile_y` update to the target tile, go to IDLE.
  - Keys pressed during MOVE stay latched. They are evaluated at the first IDLE tick, so there is one idle frame between consecutive steps.
- Simultaneous `key_valid` and request consumption on the same cycle: the new key is latched and `req_pending` stays 1.
- Window:
  - `inx` = `DrawX` ≥ `pix_x` && `DrawX` < `pix_x`+`TILE`; `iny` is the same test for y.
  - `sprite_on` = `inx` && `iny`.
  - When `sprite_on`, `DistX` = `DrawX`−`pix_x` and `DistY` = `DrawY`−`pix_y`; otherwise both are 0.
  - Arithmetic is 11-bit unsigned internally, zero-extended to 20 bits.
- `blocked` is sampled only on the IDLE tick that evaluates a request.

## Timing
- `DistX`, `DistY` and `sprite_on` are registered: 1 cycle of latency from `DrawX`/`DrawY`.
- Motion latency:
  - `vs` falling edge → tick: 2 cycles.
  - Tick → `pix_*`/`tile_*`/`facing`/`moving` update: 1 cycle.
  - One tile takes `TILE`/`STEP` = 10 frames.
- Reset values:
  - `pix_x` = `START_X`·`TILE`, `pix_y` = `START_Y`·`TILE`.
  - `tile_x` = `START_X`, `tile_y` = `START_Y`.
  - `facing` = 2 (down).
  - `moving`, `DistX`, `DistY`, `sprite_on`, `walk_frame`, `req_pending`: all 0.
  - FSM = IDLE.
- Reset asserted mid-move returns the sprite to the start tile immediately, with no partial step retained.

## Configuration
- `SPRITE_ANIM_EN` defined: a frame-tick counter runs only in MOVE.
  - `walk_frame` increments every 4 ticks, wrapping 3→0.
  - It returns to 0 on entering IDLE.
- `SPRITE_ANIM_EN` undefined: `walk_frame` is constant 0 and the counter is not built.

## Structure
- Package `pokemaze_pkg` holds:
  - `dir_t` enum (UP, RIGHT, DOWN, LEFT).
  - `ctrl_state_t` enum (IDLE, MOVE).
  - Keycode constants `KEY_W`/`KEY_A`/`KEY_S`/`KEY_D`.
- Sub-module `frame_tick_gen`: synchronous `vs` falling-edge detector producing the one-cycle tick; reset on `reset_n`.

## Test plan
- Reset, then no keys for 3 frames → `tile` = (1,1), `pix` = (20,20), `facing` = 2, `moving` = 0.
- D key (0x07), `blocked` = 0:
  - Next tick → `moving` = 1, `facing` = 1.
  - After 10 ticks → `pix_x` = 40, `tile_x` = 2, `moving` = 0.
- W key with `blocked[0]` = 1 → `facing` = 0, `moving` stays 0, position unchanged, `req_pending` cleared.
- Boundary: at tile (0,5), A key → refused, `facing` = 3, `pix_x` stays 0.
- Window, sprite at (40,20):
  - `DrawX`/`DrawY` = (45,33) → next cycle `sprite_on` = 1, `DistX` = 5, `DistY` = 13.
  - (60,20) → `sprite_on` = 0, `Dist*` = 0.
- Reset pulse at tick 5 of a move → `pix` = (20,20) and IDLE. With `SPRITE_ANIM_EN`, `walk_frame` = 1 after 4 ticks of a move and 0 after reset.

Source files
------------

// File: rtl/pokemaze_pkg.sv
// Shared types and keycode constants for the maze player sprite path.
package pokemaze_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef enum logic {
        IDLE = 1'b0,
        MOVE = 1'b1
    } ctrl_state_t;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;

    // True for the four movement keys.
    function automatic logic key_is_dir(input logic [7:0] k);
        return (k == KEY_W) || (k == KEY_D) || (k == KEY_S) || (k == KEY_A);
    endfunction

    // Movement key to direction; only meaningful when key_is_dir() holds.
    function automatic dir_t key_to_dir(input logic [7:0] k);
        dir_t d;
        case (k)
            KEY_W:   d = UP;
            KEY_D:   d = RIGHT;
            KEY_S:   d = DOWN;
            default: d = LEFT;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/player_sprite_ctrl_if.sv
// Signal bundle between the VGA/keyboard/maze side and the sprite controller.
interface player_sprite_ctrl_if;

    logic        vs;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [7:0]  keycode;
    logic        key_valid;
    logic [3:0]  blocked;

    logic [4:0]  tile_x;
    logic [4:0]  tile_y;
    logic [19:0] DistX;
    logic [19:0] DistY;
    logic        sprite_on;
    logic [1:0]  facing;
    logic        moving;
    logic [1:0]  walk_frame;

    modport master (
        output vs, DrawX, DrawY, keycode, key_valid, blocked,
        input  tile_x, tile_y, DistX, DistY, sprite_on, facing, moving, walk_frame
    );

    modport slave (
        input  vs, DrawX, DrawY, keycode, key_valid, blocked,
        output tile_x, tile_y, DistX, DistY, sprite_on, facing, moving, walk_frame
    );

endinterface

// File: rtl/player_sprite_ctrl_tick.sv
// Frame tick generator: one-cycle pulse the cycle after a registered falling
// edge of the active-low vertical sync.
module frame_tick_gen (
    input  logic vga_clk,
    input  logic reset_n,
    input  logic vs_i,
    output logic tick_o
);

    logic vs_q1;
    logic vs_q2;
    logic tick_q;

    // Two-stage vs history (idles high) and registered falling-edge pulse.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_q1  <= 1'b1;
            vs_q2  <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            vs_q1  <= vs_i;
            vs_q2  <= vs_q1;
            tick_q <= vs_q2 & ~vs_q1;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/player_sprite_ctrl.sv
// Maze player position and sprite-window controller.
// Steps the sprite one tile at a time on frame ticks, honouring wall flags,
// and produces the registered per-pixel sprite window for the draw stage.
// Optional walk animation counter: define SPRITE_ANIM_EN.
//
// state | meaning
// IDLE  | at rest on a tile; a pending key is evaluated on the next tick
// MOVE  | sliding STEP pixels per tick towards the target tile
module player_sprite_ctrl
    import pokemaze_pkg::*;
#(
    parameter int TILE    = 20,
    parameter int STEP    = 2,
    parameter int GRID_W  = 32,
    parameter int GRID_H  = 24,
    parameter int START_X = 1,
    parameter int START_Y = 1
) (
    input  logic                vga_clk,
    input  logic                reset_n,
    player_sprite_ctrl_if.slave bus
);

    localparam logic [10:0] TILE_W   = 11'(TILE);
    localparam logic [10:0] STEP_W   = 11'(STEP);
    localparam logic [10:0] START_PX = 11'(START_X * TILE);
    localparam logic [10:0] START_PY = 11'(START_Y * TILE);
    localparam logic [4:0]  START_TX = 5'(START_X);
    localparam logic [4:0]  START_TY = 5'(START_Y);
    localparam logic [4:0]  MAX_TX   = 5'(GRID_W - 1);
    localparam logic [4:0]  MAX_TY   = 5'(GRID_H - 1);

    logic        tick;

    ctrl_state_t state_q, state_d;
    dir_t        facing_q, facing_d;
    dir_t        req_dir_q;
    logic        req_pending_q;
    logic        consume;
    logic [4:0]  tile_x_q, tile_x_d;
    logic [4:0]  tile_y_q, tile_y_d;
    logic [10:0] pix_x_q, pix_x_d;
    logic [10:0] pix_y_q, pix_y_d;
    logic [10:0] remaining_q, remaining_d;

    dir_t        mv_dir;
    logic [4:0]  tgt_x;
    logic [4:0]  tgt_y;
    logic        at_edge;

    logic [10:0] draw_x;
    logic [10:0] draw_y;
    logic        inx;
    logic        iny;
    logic        sprite_on_q;
    logic [10:0] dist_x_q;
    logic [10:0] dist_y_q;

    frame_tick_gen u_tick (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .vs_i    (bus.vs),
        .tick_o  (tick)
    );

    // Latch the most recent movement key; a new key wins over consumption.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            req_dir_q     <= DOWN;
            req_pending_q <= 1'b0;
        end else if (bus.key_valid && key_is_dir(bus.keycode)) begin
            req_dir_q     <= key_to_dir(bus.keycode);
            req_pending_q <= 1'b1;
        end else if (consume) begin
            req_pending_q <= 1'b0;
        end
    end

    // Neighbour tile in the direction of interest and whether it is off-grid.
    always_comb begin
        mv_dir  = (state_q == IDLE) ? req_dir_q : facing_q;
        tgt_x   = tile_x_q;
        tgt_y   = tile_y_q;
        at_edge = 1'b0;
        case (mv_dir)
            UP: begin
                at_edge = (tile_y_q == 5'd0);
                tgt_y   = tile_y_q - 5'd1;
            end
            RIGHT: begin
                at_edge = (tile_x_q >= MAX_TX);
                tgt_x   = tile_x_q + 5'd1;
            end
            DOWN: begin
                at_edge = (tile_y_q >= MAX_TY);
                tgt_y   = tile_y_q + 5'd1;
            end
            default: begin
                at_edge = (tile_x_q == 5'd0);
                tgt_x   = tile_x_q - 5'd1;
            end
        endcase
    end

    // Next-state logic: evaluate requests in IDLE, slide pixels in MOVE.
    always_comb begin
        state_d     = state_q;
        facing_d    = facing_q;
        tile_x_d    = tile_x_q;
        tile_y_d    = tile_y_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        remaining_d = remaining_q;
        consume     = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick && req_pending_q) begin
                    consume  = 1'b1;
                    facing_d = req_dir_q;
                    if (!bus.blocked[req_dir_q] && !at_edge) begin
                        remaining_d = TILE_W;
                        state_d     = MOVE;
                    end
                end
            end
            MOVE: begin
                if (tick) begin
                    case (facing_q)
                        UP:      pix_y_d = pix_y_q - STEP_W;
                        RIGHT:   pix_x_d = pix_x_q + STEP_W;
                        DOWN:    pix_y_d = pix_y_q + STEP_W;
                        default: pix_x_d = pix_x_q - STEP_W;
                    endcase
                    remaining_d = remaining_q - STEP_W;
                    if (remaining_d == 11'd0) begin
                        tile_x_d = tgt_x;
                        tile_y_d = tgt_y;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Position, heading and FSM state registers.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            facing_q    <= DOWN;
            tile_x_q    <= START_TX;
            tile_y_q    <= START_TY;
            pix_x_q     <= START_PX;
            pix_y_q     <= START_PY;
            remaining_q <= 11'd0;
        end else begin
            state_q     <= state_d;
            facing_q    <= facing_d;
            tile_x_q    <= tile_x_d;
            tile_y_q    <= tile_y_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            remaining_q <= remaining_d;
        end
    end

    assign draw_x = {1'b0, bus.DrawX};
    assign draw_y = {1'b0, bus.DrawY};
    assign inx    = (draw_x >= pix_x_q) && (draw_x < pix_x_q + TILE_W);
    assign iny    = (draw_y >= pix_y_q) && (draw_y < pix_y_q + TILE_W);

    // Registered sprite window and in-sprite offsets for the ROM lookup.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            sprite_on_q <= 1'b0;
            dist_x_q    <= 11'd0;
            dist_y_q    <= 11'd0;
        end else begin
            sprite_on_q <= inx && iny;
            dist_x_q    <= (inx && iny) ? (draw_x - pix_x_q) : 11'd0;
            dist_y_q    <= (inx && iny) ? (draw_y - pix_y_q) : 11'd0;
        end
    end

`ifdef SPRITE_ANIM_EN
    logic [1:0] anim_cnt_q;
    logic [1:0] walk_q;

    // Walk frame advances every fourth tick of a move, cleared on arrival.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            anim_cnt_q <= 2'd0;
            walk_q     <= 2'd0;
        end else if (tick && (state_q == MOVE)) begin
            if (state_d == IDLE) begin
                anim_cnt_q <= 2'd0;
                walk_q     <= 2'd0;
            end else begin
                anim_cnt_q <= anim_cnt_q + 2'd1;
                if (anim_cnt_q == 2'd3) begin
                    walk_q <= walk_q + 2'd1;
                end
            end
        end
    end

    assign bus.walk_frame = walk_q;
`else
    assign bus.walk_frame = 2'd0;
`endif

    assign bus.tile_x    = tile_x_q;
    assign bus.tile_y    = tile_y_q;
    assign bus.facing    = facing_q;
    assign bus.moving    = (state_q == MOVE);
    assign bus.sprite_on = sprite_on_q;
    assign bus.DistX     = {9'd0, dist_x_q};
    assign bus.DistY     = {9'd0, dist_y_q};

endmodule

// File: tb/tb_player_sprite_ctrl.sv
// Self-checking bench for player_sprite_ctrl: a frame-level reference model
// checked against the DUT every cycle, plus literal expectations.
module tb_player_sprite_ctrl;

    localparam int TILE = 20;
    localparam int STEP = 2;
    localparam int GW   = 32;
    localparam int GH   = 24;

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;

    player_sprite_ctrl_if bus ();

    player_sprite_ctrl #(
        .TILE(TILE), .STEP(STEP), .GRID_W(GW), .GRID_H(GH), .START_X(1), .START_Y(1)
    ) dut (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 vga_clk = ~vga_clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model state (player position in tiles and pixels).
    int m_tx, m_ty, m_px, m_py, m_face, m_moving, m_left, m_mticks, m_pend, m_req;
    int e_on, e_dx, e_dy;
    bit [2:0] vh;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ddx(input int d);
        return (d == 1) ? 1 : ((d == 3) ? -1 : 0);
    endfunction

    function automatic int ddy(input int d);
        return (d == 2) ? 1 : ((d == 0) ? -1 : 0);
    endfunction

    task automatic model_reset();
        m_tx = 1; m_ty = 1; m_px = TILE; m_py = TILE;
        m_face = 2; m_moving = 0; m_left = 0; m_mticks = 0;
        m_pend = 0; m_req = 2;
        e_on = 0; e_dx = 0; e_dy = 0;
        vh = 3'b111;
    endtask

    task automatic model_step();
        int x, y, ntx, nty;
        bit tick;
        x = int'(bus.DrawX);
        y = int'(bus.DrawY);
        e_on = (x >= m_px && x < m_px + TILE && y >= m_py && y < m_py + TILE) ? 1 : 0;
        e_dx = e_on ? x - m_px : 0;
        e_dy = e_on ? y - m_py : 0;
        // Frame boundary lands two clocks after vs is first seen low.
        tick = (vh[1] == 1'b0) && (vh[2] == 1'b1);
        vh   = {vh[1:0], bus.vs};
        if (tick) begin
            if (m_moving != 0) begin
                m_px += ddx(m_face) * STEP;
                m_py += ddy(m_face) * STEP;
                m_left--;
                m_mticks++;
                if (m_left == 0) begin
                    m_tx += ddx(m_face);
                    m_ty += ddy(m_face);
                    m_moving = 0;
                    m_mticks = 0;
                end
            end else if (m_pend != 0) begin
                m_face = m_req;
                m_pend = 0;
                ntx = m_tx + ddx(m_req);
                nty = m_ty + ddy(m_req);
                if (!bus.blocked[m_req] && ntx >= 0 && ntx < GW && nty >= 0 && nty < GH) begin
                    m_moving = 1;
                    m_left   = TILE / STEP;
                    m_mticks = 0;
                end
            end
        end
        if (bus.key_valid) begin
            case (bus.keycode)
                8'h1A: begin m_req = 0; m_pend = 1; end
                8'h07: begin m_req = 1; m_pend = 1; end
                8'h16: begin m_req = 2; m_pend = 1; end
                8'h04: begin m_req = 3; m_pend = 1; end
                default: ;
            endcase
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge vga_clk or negedge reset_n);
            if (!reset_n) model_reset();
            else          model_step();
        end
    end

    function automatic int exp_walk();
`ifdef SPRITE_ANIM_EN
        return (m_moving != 0) ? ((m_mticks / 4) % 4) : 0;
`else
        return 0;
`endif
    endfunction

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge vga_clk);
            if (chk_en) begin
                check("tile_x",     int'(bus.tile_x),     m_tx);
                check("tile_y",     int'(bus.tile_y),     m_ty);
                check("facing",     int'(bus.facing),     m_face);
                check("moving",     int'(bus.moving),     m_moving);
                check("walk_frame", int'(bus.walk_frame), exp_walk());
                check("sprite_on",  int'(bus.sprite_on),  e_on);
                check("DistX",      int'(bus.DistX),      e_dx);
                check("DistY",      int'(bus.DistY),      e_dy);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge vga_clk);
            #2;
        end
    endtask

    task automatic frame();
        bus.vs = 1'b0;
        step(2);
        bus.vs = 1'b1;
        step(6);
    endtask

    task automatic frames(input int n);
        repeat (n) frame();
    endtask

    task automatic press(input logic [7:0] code);
        bus.keycode   = code;
        bus.key_valid = 1'b1;
        step(1);
        bus.key_valid = 1'b0;
        bus.keycode   = 8'h00;
    endtask

    task automatic probe(input int x, input int y, input int on, input int dx, input int dy,
                         input string name);
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        step(1);
        check({name, ".sprite_on"}, int'(bus.sprite_on), on);
        check({name, ".DistX"},     int'(bus.DistX),     dx);
        check({name, ".DistY"},     int'(bus.DistY),     dy);
    endtask

    int walk_exp;

    initial begin
        bus.vs        = 1'b1;
        bus.DrawX     = 10'd0;
        bus.DrawY     = 10'd0;
        bus.keycode   = 8'h00;
        bus.key_valid = 1'b0;
        bus.blocked   = 4'b0000;
        @(posedge vga_clk);
        #2;
        chk_en = 1'b1;
        step(2);
        reset_n = 1'b1;

        // Reset state held over idle frames.
        frames(3);
        check("rst.tile_x", int'(bus.tile_x), 1);
        check("rst.tile_y", int'(bus.tile_y), 1);
        check("rst.facing", int'(bus.facing), 2);
        check("rst.moving", int'(bus.moving), 0);
        check("rst.walk",   int'(bus.walk_frame), 0);
        probe(20, 20, 1, 0, 0, "rst.pix");
        probe(19, 20, 0, 0, 0, "rst.left_of");

        // D: step right one tile.
        press(8'h07);
        frame();
        check("d.moving", int'(bus.moving), 1);
        check("d.facing", int'(bus.facing), 1);
        frames(4);
`ifdef SPRITE_ANIM_EN
        walk_exp = 1;
`else
        walk_exp = 0;
`endif
        check("d.walk4", int'(bus.walk_frame), walk_exp);
        frames(6);
        check("d.tile_x", int'(bus.tile_x), 2);
        check("d.moving_done", int'(bus.moving), 0);
        probe(45, 33, 1, 5, 13, "win.in");
        probe(60, 20, 0, 0, 0, "win.right_edge");
        probe(59, 39, 1, 19, 19, "win.corner");

        // W into a wall: turn in place, request consumed.
        bus.blocked = 4'b0001;
        press(8'h1A);
        frame();
        check("w.facing", int'(bus.facing), 0);
        check("w.moving", int'(bus.moving), 0);
        check("w.tile_y", int'(bus.tile_y), 1);
        bus.blocked = 4'b0000;
        frame();
        check("w.no_replay", int'(bus.moving), 0);
        probe(40, 20, 1, 0, 0, "w.pix");

        // Unrecognised keycode is ignored.
        press(8'h05);
        frame();
        check("badkey.moving", int'(bus.moving), 0);

        // Walk to (0,5); first down move uses W overwritten by S.
        press(8'h04); frames(11);
        press(8'h04); frames(11);
        check("a2.tile_x", int'(bus.tile_x), 0);
        press(8'h1A);
        press(8'h16); frames(11);
        press(8'h16); frames(11);
        press(8'h16); frames(11);
        press(8'h16); frames(11);
        check("s4.tile_x", int'(bus.tile_x), 0);
        check("s4.tile_y", int'(bus.tile_y), 5);
        check("s4.facing", int'(bus.facing), 2);

        // Left edge of the grid: refused, turn only.
        press(8'h04);
        frame();
        check("edge.facing", int'(bus.facing), 3);
        check("edge.moving", int'(bus.moving), 0);
        probe(0, 100, 1, 0, 0, "edge.pix");

        // Key arriving on the same cycle the pending request is consumed.
        press(8'h16);
        bus.vs = 1'b0;
        step(2);
        bus.keycode   = 8'h07;
        bus.key_valid = 1'b1;
        step(1);
        bus.key_valid = 1'b0;
        bus.keycode   = 8'h00;
        bus.vs        = 1'b1;
        step(5);
        check("sim.moving", int'(bus.moving), 1);
        check("sim.facing", int'(bus.facing), 2);
        frames(10);
        check("sim.tile_y", int'(bus.tile_y), 6);
        check("sim.idle",   int'(bus.moving), 0);
        frame();
        check("sim.d_moving", int'(bus.moving), 1);
        check("sim.d_facing", int'(bus.facing), 1);

        // Reset in the middle of that move.
        frames(5);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        check("mrst.tile_x", int'(bus.tile_x), 1);
        check("mrst.tile_y", int'(bus.tile_y), 1);
        check("mrst.moving", int'(bus.moving), 0);
        check("mrst.facing", int'(bus.facing), 2);
        check("mrst.walk",   int'(bus.walk_frame), 0);
        probe(20, 20, 1, 0, 0, "mrst.pix");
        frame();
        check("mrst.stays", int'(bus.moving), 0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
